// File: rtl/me_mem_loader.sv
// Host-side loader for the motion-estimation core: streams TB/SW pixels into memory, runs req/ack, returns result.
// Optional ME_LOADER_CHECKSUM_EN adds a load_sum output (mod-2^16 sum of accepted bytes per frame).
module me_mem_loader #(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    localparam int ADDR_TB     = $clog2(TB_LENGTH * TB_LENGTH),
    localparam int ADDR_SW     = $clog2(SW_LENGTH * SW_LENGTH),
    localparam int SAD_WIDTH   = ADDR_TB + PE_OUT_WIDTH,
    localparam int CNT_WIDTH   = $clog2((SW_LENGTH - TB_LENGTH + 1) * (SW_LENGTH - TB_LENGTH + 1))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 load_active,
    output logic                 wren_tb,
    output logic [ADDR_TB-1:0]   addr_tb,
    output logic [7:0]           data_tb,
    output logic                 wren_sw,
    output logic [ADDR_SW-1:0]   addr_sw,
    output logic [7:0]           data_sw,
    output logic                 req,
    input  logic                 ack,
    input  logic [SAD_WIDTH-1:0] min_sad,
    input  logic [CNT_WIDTH-1:0] min_mvec,
    output logic [SAD_WIDTH-1:0] res_sad,
    output logic [CNT_WIDTH-1:0] res_mvec,
    output logic                 res_valid,
    input  logic                 res_ready
`ifdef ME_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]          load_sum
`endif
);

    localparam int LD_W = (ADDR_SW > ADDR_TB) ? ADDR_SW : ADDR_TB;
    localparam logic [LD_W-1:0] TB_LAST = LD_W'(TB_LENGTH * TB_LENGTH - 1);
    localparam logic [LD_W-1:0] SW_LAST = LD_W'(SW_LENGTH * SW_LENGTH - 1);

    typedef enum logic [2:0] {
        LOAD_TB,
        LOAD_SW,
        SETTLE,
        REQ,
        ACK_LOW,
        RESULT
    } state_t;

    state_t          state, state_n;
    logic [LD_W-1:0] cnt, cnt_n;
    logic            beat;
    logic            in_ready_n, load_active_n, req_n, res_valid_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beat    = in_valid && in_ready;
        case (state)
            LOAD_TB: if (beat) begin
                if (cnt == TB_LAST) begin
                    cnt_n   = '0;
                    state_n = LOAD_SW;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LOAD_SW: if (beat) begin
                if (cnt == SW_LAST) begin
                    cnt_n   = '0;
                    state_n = SETTLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SETTLE:  state_n = REQ;
            REQ:     if (ack) state_n = ACK_LOW;
            ACK_LOW: if (!ack) state_n = RESULT;
            RESULT:  if (res_ready) state_n = LOAD_TB;
            default: state_n = LOAD_TB;
        endcase
        // Handshake outputs are registered from the next state so they hold 0 throughout reset.
        in_ready_n    = (state_n == LOAD_TB) || (state_n == LOAD_SW);
        load_active_n = in_ready_n || (state_n == SETTLE);
        req_n         = (state_n == REQ);
        res_valid_n   = (state_n == RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD_TB;
            cnt         <= '0;
            in_ready    <= 1'b0;
            load_active <= 1'b0;
            req         <= 1'b0;
            res_valid   <= 1'b0;
            wren_tb     <= 1'b0;
            addr_tb     <= '0;
            data_tb     <= '0;
            wren_sw     <= 1'b0;
            addr_sw     <= '0;
            data_sw     <= '0;
            res_sad     <= '0;
            res_mvec    <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            in_ready    <= in_ready_n;
            load_active <= load_active_n;
            req         <= req_n;
            res_valid   <= res_valid_n;
            wren_tb     <= beat && (state == LOAD_TB);
            wren_sw     <= beat && (state == LOAD_SW);
            if (beat && state == LOAD_TB) begin
                addr_tb <= cnt[ADDR_TB-1:0];
                data_tb <= in_data;
            end
            if (beat && state == LOAD_SW) begin
                addr_sw <= cnt[ADDR_SW-1:0];
                data_sw <= in_data;
            end
            if (state == REQ && ack) begin
                res_sad  <= min_sad;
                res_mvec <= min_mvec;
            end
        end
    end

`ifdef ME_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || (state == RESULT && res_ready)) begin
            load_sum <= '0;
        end else if (beat) begin
            load_sum <= load_sum + 16'(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_me_mem_loader.sv
// Directed self-checking bench for me_mem_loader: ramp frame, bubbled frame, ack-ignore, mid-load reset.
module tb_me_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        load_active;
    logic        wren_tb;
    logic [7:0]  addr_tb;
    logic [7:0]  data_tb;
    logic        wren_sw;
    logic [11:0] addr_sw;
    logic [7:0]  data_sw;
    logic        req;
    logic        ack;
    logic [15:0] min_sad;
    logic [11:0] min_mvec;
    logic [15:0] res_sad;
    logic [11:0] res_mvec;
    logic        res_valid;
    logic        res_ready;
`ifdef ME_LOADER_CHECKSUM_EN
    logic [15:0] load_sum;
`endif

    int total = 0;
    int bad   = 0;

    me_mem_loader #(
        .TB_LENGTH   (16),
        .SW_LENGTH   (64),
        .PE_OUT_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_active(load_active),
        .wren_tb    (wren_tb),
        .addr_tb    (addr_tb),
        .data_tb    (data_tb),
        .wren_sw    (wren_sw),
        .addr_sw    (addr_sw),
        .data_sw    (data_sw),
        .req        (req),
        .ack        (ack),
        .min_sad    (min_sad),
        .min_mvec   (min_mvec),
        .res_sad    (res_sad),
        .res_mvec   (res_mvec),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
`ifdef ME_LOADER_CHECKSUM_EN
        ,
        .load_sum   (load_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int k, input bit ff);
        int v;
        if (ff) return 8'hFF;
        v = (k < 256) ? k : (k - 256) * 3;
        return v[7:0];
    endfunction

    // Drives beats first..first+count-1 of a frame and checks the registered write of each one.
    task automatic load_beats(input int first, input int count, input bit bubbles, input bit ff);
        int k;
        int cyc;
        bit v;
        int rel;
        logic [11:0] a;
        k   = first;
        cyc = 0;
        while (k < first + count && cyc < 20000) begin
            v        = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid = v;
            in_data  = pix(k, ff);
            check("in_ready_load", in_ready, 1'b1);
            tick();
            cyc++;
            if (v) begin
                if (k < 256) begin
                    a = 12'(k);
                    check("tb_write", {wren_tb, wren_sw, addr_tb, data_tb}, {2'b10, a[7:0], pix(k, ff)});
                end else begin
                    rel = k - 256;
                    a   = rel[11:0];
                    check("sw_write", {wren_tb, wren_sw, addr_sw, data_sw}, {2'b01, a, pix(k, ff)});
                end
                k++;
            end else begin
                check("idle_no_write", {wren_tb, wren_sw}, 2'b00);
            end
        end
        check("load_budget", 32'(k), 32'(first + count));
        in_valid = 1'b0;
    endtask

    // Entered #1 after the edge that accepted the last SW beat.
    task automatic handshake(input int delay, input int ack_len, input logic [15:0] sad,
                             input logic [11:0] mvec, input int hold, input bit ff);
        check("settle_ctl", {in_ready, load_active, req}, 3'b010);
        tick();
        check("req_rise", {req, load_active, wren_tb, wren_sw}, 4'b1000);
        for (int i = 1; i < delay; i++) begin
            tick();
            check("req_held", {req, res_valid}, 2'b10);
        end
        ack      = 1'b1;
        min_sad  = sad;
        min_mvec = mvec;
        for (int i = 0; i < ack_len; i++) begin
            tick();
            check("ack_capture", {req, res_valid, res_sad, res_mvec}, {2'b00, sad, mvec});
        end
        ack      = 1'b0;
        min_sad  = 16'hDEAD;
        min_mvec = 12'hBAD;
        tick();
        check("res_valid_rise", {res_valid, in_ready, res_sad, res_mvec}, {2'b10, sad, mvec});
        for (int i = 0; i < hold; i++) begin
            tick();
            check("res_hold", {res_valid, in_ready, res_sad, res_mvec}, {2'b10, sad, mvec});
`ifdef ME_LOADER_CHECKSUM_EN
            if (ff) check("load_sum", load_sum, 16'hEF00);
`endif
        end
        res_ready = 1'b1;
        tick();
        check("res_accept", {res_valid, in_ready, load_active, req}, 4'b0110);
`ifdef ME_LOADER_CHECKSUM_EN
        check("load_sum_clear", load_sum, 16'h0000);
`endif
        res_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        ack       = 1'b0;
        min_sad   = '0;
        min_mvec  = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check("reset_outputs", {in_ready, load_active, wren_tb, addr_tb, data_tb, wren_sw, addr_sw,
                                data_sw, req, res_sad, res_mvec, res_valid}, 70'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", {in_ready, load_active, req}, 3'b110);

        // Frame 1: ramp, no bubbles, slow stub and a stalled consumer.
        load_beats(0, 4352, 1'b0, 1'b0);
        handshake(20, 3, 16'h0123, 12'h4A5, 10, 1'b0);

        // Frame 2: same data with random bubbles, fast stub.
        load_beats(0, 4352, 1'b1, 1'b0);
        handshake(2, 1, 16'h0BEE, 12'h123, 2, 1'b0);

        // Frame 3: ack pulse during LOAD_SW is ignored, then reset mid-load.
        load_beats(0, 1256, 1'b0, 1'b0);
        ack     = 1'b1;
        min_sad = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ack_ignored", {req, in_ready, wren_tb, wren_sw, res_sad, res_mvec}, {4'b0100, 16'h0BEE, 12'h123});
        end
        ack = 1'b0;
        load_beats(1256, 10, 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        check("midload_reset", {in_ready, load_active, wren_tb, addr_tb, data_tb, wren_sw, addr_sw,
                                data_sw, req, res_sad, res_mvec, res_valid}, 70'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("ready_after_reset2", {in_ready, load_active, wren_tb, wren_sw}, 4'b1100);

        // Frame 4: restart from TB address 0; all-0xFF for the checksum build.
`ifdef ME_LOADER_CHECKSUM_EN
        load_beats(0, 4352, 1'b0, 1'b1);
        handshake(5, 2, 16'h4321, 12'h0F0, 3, 1'b1);
`else
        load_beats(0, 4352, 1'b0, 1'b0);
        handshake(5, 2, 16'h4321, 12'h0F0, 3, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
